// File: rtl/mod_w_wnd_comp_pkg.sv
// Shared definitions for the SHA-256 compression engine:
// command codes, FSM encoding, working-register bundle,
// SHA-256 initial values and the FIPS 180-4 logic functions.
package mod_w_wnd_comp_pkg;

  localparam logic [7:0] CODE_IDLE        = 8'd0;
  localparam logic [7:0] CODE_LOAD_H      = 8'd1;
  localparam logic [7:0] CODE_HASH        = 8'd2;
  localparam logic [7:0] CODE_SUM_STORE_H = 8'd3;
  localparam logic [7:0] CODE_SUM_STORE_M = 8'd4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    HASH   = 3'd2,
    SUM    = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5
  } fsm_state_t;

  // a sits in the MSBs so the packed bundle reads as the digest word order
  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } work_t;

  localparam logic [31:0] IV0 = 32'h6a09e667;
  localparam logic [31:0] IV1 = 32'hbb67ae85;
  localparam logic [31:0] IV2 = 32'h3c6ef372;
  localparam logic [31:0] IV3 = 32'ha54ff53a;
  localparam logic [31:0] IV4 = 32'h510e527f;
  localparam logic [31:0] IV5 = 32'h9b05688c;
  localparam logic [31:0] IV6 = 32'h1f83d9ab;
  localparam logic [31:0] IV7 = 32'h5be0cd19;
  localparam logic [255:0] IV_ALL = {IV0, IV1, IV2, IV3, IV4, IV5, IV6, IV7};

  // Sigma0: ROTR2 ^ ROTR13 ^ ROTR22
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  // Sigma1: ROTR6 ^ ROTR11 ^ ROTR25
  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  // sigma0: ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1: ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/mod_w_wnd_comp_if.sv
// Memory/command port bundle of the SHA-256 engine. The master is the
// sequencer/memory side, the slave is the engine.
interface mod_w_wnd_comp_if;
  logic [7:0]   CMD;
  logic [7:0]   MKA;
  logic [31:0]  MD_IN;
  logic [31:0]  KD;
  logic [7:0]   HA;
  logic [31:0]  HD_IN;
  logic [31:0]  HD_OUT;
  logic [31:0]  MD_OUT;
  logic [255:0] RES;
  logic         RDY;

  modport master (output CMD, MD_IN, KD, HD_IN,
                  input  MKA, HA, HD_OUT, MD_OUT, RES, RDY);
  modport slave  (input  CMD, MD_IN, KD, HD_IN,
                  output MKA, HA, HD_OUT, MD_OUT, RES, RDY);
endinterface

// File: rtl/mod_w_wnd_comp_sha256_round.sv
// One combinational SHA-256 round: current a..h, K_t and W_t in,
// next a..h out.
module sha256_round
  import mod_w_wnd_comp_pkg::*;
(
  input  work_t       cur,
  input  logic [31:0] kd,
  input  logic [31:0] wt,
  output work_t       nxt
);

  logic [31:0] t1;
  logic [31:0] t2;

  // Compute T1/T2 and rotate the working registers.
  always_comb begin
    t1    = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + kd + wt;
    t2    = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
    nxt.a = t1 + t2;
    nxt.b = cur.a;
    nxt.c = cur.b;
    nxt.d = cur.c;
    nxt.e = cur.d + t1;
    nxt.f = cur.e;
    nxt.g = cur.f;
    nxt.h = cur.g;
  end

endmodule

// File: rtl/mod_w_wnd_comp.sv
// SHA-256 compression engine with a 16-word sliding message-schedule
// window, sequenced by LOAD_H / HASH / SUM_STORE_H / SUM_STORE_M commands.
// Optional: define W_WND_COMP_RES_EN to drive RES = IV + a..h; otherwise
// RES is tied to zero.
module mod_w_wnd_comp
  import mod_w_wnd_comp_pkg::*;
(
  input logic             CLK,
  input logic             RST,
  mod_w_wnd_comp_if.slave bus
);

  localparam logic [7:0] CMD_IDLE        = CODE_IDLE;
  localparam logic [7:0] CMD_LOAD_H      = CODE_LOAD_H;
  localparam logic [7:0] CMD_HASH        = CODE_HASH;
  localparam logic [7:0] CMD_SUM_STORE_H = CODE_SUM_STORE_H;
  localparam logic [7:0] CMD_SUM_STORE_M = CODE_SUM_STORE_M;

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] w [16];
  logic [6:0]  cnt;
  logic [2:0]  ha;
  logic [5:0]  mka;
  fsm_state_t  state;
  fsm_state_t  state_next;
  logic        rdy;
  logic [31:0] wt;
  logic [31:0] sel;
  work_t       cur;
  work_t       nxt;

  assign cur = {a, b, c, d, e, f, g, h};

  sha256_round u_round (
    .cur (cur),
    .kd  (bus.KD),
    .wt  (wt),
    .nxt (nxt)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: commands only matter in IDLE; unknown codes are ignored.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        case (bus.CMD)
          CMD_IDLE:                         state_next = IDLE;
          CMD_LOAD_H:                       state_next = LOAD;
          CMD_HASH:                         state_next = HASH;
          CMD_SUM_STORE_H, CMD_SUM_STORE_M: state_next = SUM;
          default:                          state_next = IDLE;
        endcase
      end
      LOAD, SUM: if (cnt == 7'd7)  state_next = SETTLE;
      HASH:      if (cnt == 7'd63) state_next = SETTLE;
      SETTLE:    state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state: RDY is the single DONE cycle.
  always_comb begin
    rdy = (state == DONE);
  end

  // Schedule word: straight from memory for the first 16 rounds, then
  // expanded from the window (w[15] is W_{t-1}, w[0] is W_{t-16}).
  always_comb begin
    if (cnt < 7'd16) wt = bus.MD_IN;
    else             wt = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
  end

  // Counter, address registers and working registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      ha  <= '0;
      mka <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (state_next != IDLE) begin
            cnt <= '0;
            ha  <= '0;
            mka <= '0;
          end
        end
        LOAD: begin
          case (ha)
            3'd0: a <= bus.HD_IN;
            3'd1: b <= bus.HD_IN;
            3'd2: c <= bus.HD_IN;
            3'd3: d <= bus.HD_IN;
            3'd4: e <= bus.HD_IN;
            3'd5: f <= bus.HD_IN;
            3'd6: g <= bus.HD_IN;
            default: h <= bus.HD_IN;
          endcase
          // the last index is held so HA stays on 7 through SETTLE
          if (cnt != 7'd7) begin
            cnt <= cnt + 7'd1;
            ha  <= ha + 3'd1;
          end
        end
        SUM: begin
          if (cnt != 7'd7) begin
            cnt <= cnt + 7'd1;
            ha  <= ha + 3'd1;
          end
        end
        HASH: begin
          {a, b, c, d, e, f, g, h} <= nxt;
          if (cnt != 7'd63) begin
            cnt <= cnt + 7'd1;
            mka <= mka + 6'd1;
          end
        end
        DONE: begin
          ha  <= '0;
          mka <= '0;
        end
        default: ;
      endcase
    end
  end

  // Sliding window: shift in W_t on every hash round.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (state == HASH) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
      w[15] <= wt;
    end
  end

  // Working register addressed by HA, for the feed-forward sum.
  always_comb begin
    case (ha)
      3'd0:    sel = a;
      3'd1:    sel = b;
      3'd2:    sel = c;
      3'd3:    sel = d;
      3'd4:    sel = e;
      3'd5:    sel = f;
      3'd6:    sel = g;
      default: sel = h;
    endcase
  end

  assign bus.HD_OUT = bus.HD_IN + sel;
  assign bus.MD_OUT = bus.HD_IN + sel;
  assign bus.HA     = {5'd0, ha};
  assign bus.MKA    = {2'd0, mka};
  assign bus.RDY    = rdy;

`ifdef W_WND_COMP_RES_EN
  logic [255:0] res_sum;

  // Digest: IV plus working registers, lane by lane.
  always_comb begin
    res_sum = '0;
    for (int i = 0; i < 8; i++)
      res_sum[255-32*i -: 32] = IV_ALL[255-32*i -: 32] + cur[255-32*i -: 32];
  end

  assign bus.RES = res_sum;
`else
  assign bus.RES = '0;
`endif

endmodule

// File: tb/tb_mod_w_wnd_comp.sv
// Self-checking bench for mod_w_wnd_comp: genesis double-SHA-256 flow,
// reset behaviour, ignored commands and randomized blocks checked against
// a whole-block SHA-256 compression model.
module tb_mod_w_wnd_comp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  mod_w_wnd_comp_if bus();

  mod_w_wnd_comp dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] ktab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV_V = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] BLK1 = {32'h01000000, 256'd0,
    32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa};
  localparam logic [511:0] BLK2 = {32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c,
    32'h80000000, 320'd0, 32'h00000280};
  localparam logic [255:0] SPEC_RAW1 = 256'h5286b3cc_a7f1116b_545db90b_7909d56e_72ba866a_b3fb9b3c_772dad8b_eb392c02;
  localparam logic [255:0] SPEC_RES  = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

  logic [31:0]  hbank [8];
  logic [31:0]  msg [16];
  logic [7:0]   ha_tr [256];
  logic [7:0]   mka_tr [256];
  logic [31:0]  cap_h [8];
  logic [31:0]  cap_m [8];
  logic [255:0] h1_v;
  logic [255:0] d1_v;
  logic [255:0] exp_regs;

  assign bus.HD_IN = hbank[bus.HA[2:0]];
  assign bus.MD_IN = msg[bus.MKA[3:0]];
  assign bus.KD    = ktab[bus.MKA[5:0]];

  // ---------------- reference model ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Full-block compression without feed-forward, schedule expanded up front.
  function automatic logic [255:0] model_raw(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  wv [64];
    logic [31:0]  s [8];
    logic [31:0]  t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) wv[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      wv[i] = (rr(wv[i-2], 17) ^ rr(wv[i-2], 19) ^ (wv[i-2] >> 10)) + wv[i-7]
            + (rr(wv[i-15], 7) ^ rr(wv[i-15], 18) ^ (wv[i-15] >> 3)) + wv[i-16];
    for (int i = 0; i < 8; i++) s[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25))
         + ((s[4] & s[5]) | (~s[4] & s[6])) + ktab[t] + wv[t];
      t2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22))
         + ((s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]));
      s[7] = s[6]; s[6] = s[5]; s[5] = s[4]; s[4] = s[3] + t1;
      s[3] = s[2]; s[2] = s[1]; s[1] = s[0]; s[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = s[i];
    return r;
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = x[255-32*i -: 32] + y[255-32*i -: 32];
    return r;
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [255:0] regs_now();
    return {dut.a, dut.b, dut.c, dut.d, dut.e, dut.f, dut.g, dut.h};
  endfunction

  function automatic void set_hbank(input logic [255:0] v);
    for (int i = 0; i < 8; i++) hbank[i] = v[255-32*i -: 32];
  endfunction

  function automatic void set_msg(input logic [511:0] v);
    for (int i = 0; i < 16; i++) msg[i] = v[511-32*i -: 32];
  endfunction

  function automatic logic [255:0] cap_h_bits();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = cap_h[i];
    return r;
  endfunction

  function automatic logic [255:0] cap_m_bits();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = cap_m[i];
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = $urandom();
    return r;
  endfunction

  // Issue a command, hold it until RDY, trace HA/MKA/sums per cycle.
  // lat = number of edges from the accept edge to the edge where RDY rose.
  task automatic run_cmd(input logic [7:0] code, input int chg_at, input logic [7:0] chg_val,
                         input string tag, output int lat);
    int n;
    bit done;
    n = 0;
    done = 0;
    @(negedge clk);
    bus.CMD = code;
    while (!done && n < 200) begin
      @(posedge clk);
      @(negedge clk);
      ha_tr[n]  = bus.HA;
      mka_tr[n] = bus.MKA;
      cap_h[bus.HA[2:0]] = bus.HD_OUT;
      cap_m[bus.HA[2:0]] = bus.MD_OUT;
      if (n == chg_at) bus.CMD = chg_val;
      if (bus.RDY === 1'b1) done = 1;
      else n++;
    end
    bus.CMD = 8'd0;
    lat = n;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s timeout: no RDY after %0d edges, required RDY", tag, n);
    end
    @(negedge clk);
    total++;
    if (bus.RDY !== 1'b0) begin
      bad++;
      $display("FAIL %s rdy_pulse: RDY=%b one cycle later, required 0", tag, bus.RDY);
    end
    $display("cmd %0d (%s) done: latency=%0d", code, tag, lat);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_hbank(rand256());
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (regs_now() !== 256'd0) begin bad++; $display("FAIL reset_regs: got %h required 0", regs_now()); end
    total++;
    if (bus.HA !== 8'd0 || bus.MKA !== 8'd0 || bus.RDY !== 1'b0) begin
      bad++; $display("FAIL reset_ports: HA=%h MKA=%h RDY=%b required 0 0 0", bus.HA, bus.MKA, bus.RDY);
    end
    total++;
    if (bus.HD_OUT !== hbank[0] || bus.MD_OUT !== hbank[0]) begin
      bad++; $display("FAIL reset_sum: HD_OUT=%h MD_OUT=%h required %h", bus.HD_OUT, bus.MD_OUT, hbank[0]);
    end
    rst = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_load_iv();
    int lat;
    set_hbank(IV_V);
    run_cmd(8'd1, -1, 8'd0, "load_iv", lat);
    total++;
    if (lat !== 9) begin bad++; $display("FAIL load_latency: got %0d required 9", lat); end
    total++;
    if (regs_now() !== IV_V) begin bad++; $display("FAIL load_iv_regs: got %h required %h", regs_now(), IV_V); end
  endtask

  task automatic test_hash_genesis();
    int lat;
    int errs;
    logic [255:0] exp;
    set_msg(BLK1);
    run_cmd(8'd2, -1, 8'd0, "hash_blk1", lat);
    exp = model_raw(IV_V, BLK1);
    total++;
    if (lat !== 65) begin bad++; $display("FAIL hash_latency: got %0d required 65", lat); end
    total++;
    if (regs_now() !== exp) begin bad++; $display("FAIL hash1_model: got %h required %h", regs_now(), exp); end
    total++;
    if (regs_now() !== SPEC_RAW1) begin bad++; $display("FAIL hash1_vector: got %h required %h", regs_now(), SPEC_RAW1); end
    errs = 0;
    for (int i = 0; i < 64; i++) if (mka_tr[i] !== 8'(i)) errs++;
    if (mka_tr[64] !== 8'd63) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL mka_trace: %0d wrong cycles, required 0 (MKA=t, held 63 in settle)", errs); end
    exp_regs = exp;
  endtask

  task automatic test_sum_h();
    int lat;
    int errs;
    logic [255:0] exp;
    set_hbank(IV_V);
    run_cmd(8'd3, -1, 8'd0, "sum_h", lat);
    exp = add8(IV_V, exp_regs);
    total++;
    if (lat !== 9) begin bad++; $display("FAIL sum_latency: got %0d required 9", lat); end
    errs = 0;
    for (int i = 0; i < 8; i++) if (ha_tr[i] !== 8'(i)) errs++;
    if (ha_tr[8] !== 8'd7) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL ha_trace: %0d wrong cycles, required 0 (HA=i, held 7)", errs); end
    total++;
    if (cap_h_bits() !== exp) begin bad++; $display("FAIL sum_h_model: got %h required %h", cap_h_bits(), exp); end
    total++;
    if (cap_h[0] !== 32'hbc909a33 || cap_h[1] !== 32'h6358bff0 || cap_h[7] !== 32'h4719f91b) begin
      bad++; $display("FAIL sum_h_vector: got %h %h %h required bc909a33 6358bff0 4719f91b", cap_h[0], cap_h[1], cap_h[7]);
    end
    h1_v = exp;
  endtask

  task automatic test_block2();
    int lat;
    logic [255:0] exp;
    set_hbank(h1_v);
    run_cmd(8'd1, -1, 8'd0, "load_h1", lat);
    total++;
    if (regs_now() !== h1_v) begin bad++; $display("FAIL load_h1_regs: got %h required %h", regs_now(), h1_v); end
    set_msg(BLK2);
    run_cmd(8'd2, -1, 8'd0, "hash_blk2", lat);
    exp = model_raw(h1_v, BLK2);
    total++;
    if (regs_now() !== exp) begin bad++; $display("FAIL hash2_model: got %h required %h", regs_now(), exp); end
    total++;
    if (dut.a !== 32'hf2b168eb || dut.h !== 32'h2aabdd52) begin
      bad++; $display("FAIL hash2_vector: a=%h h=%h required f2b168eb 2aabdd52", dut.a, dut.h);
    end
    exp_regs = exp;
  endtask

  task automatic test_sum_m();
    int lat;
    logic [255:0] exp;
    set_hbank(h1_v);
    run_cmd(8'd4, -1, 8'd0, "sum_m", lat);
    exp = add8(h1_v, exp_regs);
    total++;
    if (cap_m_bits() !== exp) begin bad++; $display("FAIL sum_m_model: got %h required %h", cap_m_bits(), exp); end
    total++;
    if (cap_m[0] !== 32'haf42031e || cap_m[7] !== 32'h71c5d66d) begin
      bad++; $display("FAIL sum_m_vector: got %h %h required af42031e 71c5d66d", cap_m[0], cap_m[7]);
    end
    d1_v = exp;
  endtask

  task automatic test_second_hash();
    int lat;
    logic [511:0] blk3;
    logic [255:0] exp;
    blk3 = {d1_v, 32'h80000000, 192'd0, 32'h00000100};
    set_hbank(IV_V);
    run_cmd(8'd1, -1, 8'd0, "load_iv2", lat);
    set_msg(blk3);
    run_cmd(8'd2, -1, 8'd0, "hash_blk3", lat);
    exp = model_raw(IV_V, blk3);
    total++;
    if (regs_now() !== exp) begin bad++; $display("FAIL hash3_model: got %h required %h", regs_now(), exp); end
    total++;
    if (dut.a !== 32'h05d8a5a3) begin bad++; $display("FAIL hash3_vector: a=%h required 05d8a5a3", dut.a); end
`ifdef W_WND_COMP_RES_EN
    total++;
    if (bus.RES !== SPEC_RES) begin bad++; $display("FAIL res_digest: got %h required %h", bus.RES, SPEC_RES); end
    total++;
    if (bus.RES !== add8(IV_V, exp)) begin bad++; $display("FAIL res_model: got %h required %h", bus.RES, add8(IV_V, exp)); end
`else
    total++;
    if (bus.RES !== 256'd0) begin bad++; $display("FAIL res_tied: got %h required 0", bus.RES); end
`endif
    exp_regs = exp;
  endtask

  task automatic test_bad_cmd();
    logic [7:0] codes [4];
    int errs;
    int lat;
    codes[0] = 8'd7; codes[1] = 8'd0; codes[2] = 8'd5; codes[3] = 8'd255;
    for (int k = 0; k < 4; k++) begin
      errs = 0;
      @(negedge clk);
      bus.CMD = codes[k];
      repeat (4) begin
        @(negedge clk);
        if (bus.RDY !== 1'b0 || bus.HA !== 8'd0 || bus.MKA !== 8'd0) errs++;
      end
      total++;
      if (errs != 0) begin bad++; $display("FAIL bad_cmd_%0d: %0d cycles with RDY/HA/MKA active, required 0", codes[k], errs); end
      total++;
      if (regs_now() !== exp_regs) begin bad++; $display("FAIL bad_cmd_%0d_regs: got %h required %h", codes[k], regs_now(), exp_regs); end
      $display("ignored cmd %0d", codes[k]);
    end
    bus.CMD = 8'd0;
    set_hbank(IV_V);
    run_cmd(8'd1, -1, 8'd0, "load_after_bad", lat);
    total++;
    if (lat !== 9) begin bad++; $display("FAIL bad_cmd_idle: load latency %0d required 9", lat); end
  endtask

  task automatic test_reset_mid();
    int n;
    int lat;
    logic [255:0] hb;
    set_msg({rand256(), rand256()});
    @(negedge clk);
    bus.CMD = 8'd2;
    @(posedge clk);
    repeat (30) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (regs_now() !== 256'd0) begin bad++; $display("FAIL rst_mid_regs: got %h required 0", regs_now()); end
    total++;
    if (bus.HA !== 8'd0 || bus.MKA !== 8'd0 || bus.RDY !== 1'b0) begin
      bad++; $display("FAIL rst_mid_ports: HA=%h MKA=%h RDY=%b required 0 0 0", bus.HA, bus.MKA, bus.RDY);
    end
    bus.CMD = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.RDY !== 1'b0) n++;
    end
    total++;
    if (n != 0) begin bad++; $display("FAIL rst_mid_rdy: RDY high %0d cycles, required 0", n); end
    hb = rand256();
    set_hbank(hb);
    run_cmd(8'd1, -1, 8'd0, "load_after_rst", lat);
    total++;
    if (lat !== 9 || regs_now() !== hb) begin
      bad++; $display("FAIL rst_mid_load: latency %0d regs %h required 9 %h", lat, regs_now(), hb);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [255:0] hb, hb2, raw;
    logic [511:0] m;
    logic [7:0]   sc;
    for (int it = 0; it < 3; it++) begin
      hb = rand256();
      set_hbank(hb);
      run_cmd(8'd1, 3, 8'($urandom_range(1, 4)), "rnd_load", lat);
      total++;
      if (regs_now() !== hb) begin bad++; $display("FAIL rnd_load_%0d: got %h required %h", it, regs_now(), hb); end
      m = {rand256(), rand256()};
      set_msg(m);
      run_cmd(8'd2, 20, 8'($urandom_range(1, 4)), "rnd_hash", lat);
      raw = model_raw(hb, m);
      total++;
      if (lat !== 65 || regs_now() !== raw) begin
        bad++; $display("FAIL rnd_hash_%0d: latency %0d regs %h required 65 %h", it, lat, regs_now(), raw);
      end
      hb2 = rand256();
      set_hbank(hb2);
      sc = 8'($urandom_range(3, 4));
      run_cmd(sc, 2, 8'd1, "rnd_sum", lat);
      total++;
      if (cap_h_bits() !== add8(hb2, raw) || cap_m_bits() !== add8(hb2, raw)) begin
        bad++; $display("FAIL rnd_sum_%0d: got %h required %h", it, cap_h_bits(), add8(hb2, raw));
      end
    end
  endtask

  initial begin
    bus.CMD = 8'd0;
    set_hbank(IV_V);
    set_msg(512'd0);
    test_reset();
    test_load_iv();
    test_hash_genesis();
    test_sum_h();
    test_block2();
    test_sum_m();
    test_second_hash();
    test_bad_cmd();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
